decompressor_sequencer: RTL and testbench
=========================================

# decompressor_sequencer

Controller placed between a compressed-stream source (memory reader or FIFO) and `decompressor_top`. It unpacks 8-flag control words, issues each 16-bit item with its control bit over the decompressor's `data_in_valid`/`decompressor_busy` handshake, and counts decompressed output bytes. It also detects the end of a stream, flags a hung decompressor with a watchdog, and supports abort.

## Interface
- `COUNT_WIDTH`, 12, width of the item counter; maximum items per run is 2^COUNT_WIDTH-1.
- `BYTE_COUNT_WIDTH`, 16, width of `bytes_out`; the counter saturates at its maximum.
- `WATCHDOG_CYCLES`, 1024, number of consecutive `dec_busy`=1 cycles in ISSUE/DRAIN that counts as a hang.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored unless in IDLE.
- `item_count`  in  COUNT_WIDTH  number of items in the run (control words excluded); latched on an accepted `start`.
- `abort`  in  1  level; returns the block to IDLE from any state.
- `src_word`  in  16  stream word from the source: a control word or an item.
- `src_valid`  in  1  `src_word` is valid.
- `src_ready`  out  1  block consumes `src_word`; a transfer happens when `src_valid`=1 and `src_ready`=1 on a rising edge.
- `dec_data_in`  out  16  item presented to the decompressor.
- `dec_control_word_in`  out  1  control flag for the item: 1 = copy item, 0 = literal.
- `dec_data_in_valid`  out  1  item presented.
- `dec_busy`  in  1  decompressor busy.
- `dec_out_valid`  in  1  decompressor emitted one byte this cycle.
- `busy`  out  1  high when the block is not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a run, normal or watchdog.
- `error`  out  1  watchdog fired; sticky until the next accepted `start`.
- `bytes_out`  out  BYTE_COUNT_WIDTH  number of `dec_out_valid` cycles since the last accepted `start`.

## Operation
- Stream format: a control word, then up to 8 items, repeated. Only `src_word[7:0]` of a control word is used; bit 7 is the flag for the first item of the group and bit 0 the flag for the eighth. `src_word[15:8]` is ignored.
- A stream may end partway through a group. Unused flags in the last control word are ignored.
- State machine:
  - IDLE: `start` → if `item_count`==0, pulse `done` and stay in IDLE; otherwise latch `items_left`=`item_count`, clear `error` and `bytes_out`, go to FETCH_CW.
  - FETCH_CW: `src_ready`=1. On transfer, latch the flag byte, set `flag_idx`=0, go to FETCH_ITEM.
  - FETCH_ITEM: `src_ready`=1. On transfer, register `dec_data_in`=`src_word` and `dec_control_word_in`=flags[7-`flag_idx`], go to ISSUE.
  - ISSUE: `dec_data_in_valid`=1. On an edge with `dec_busy`=0 the item is accepted: decrement `items_left`, increment `flag_idx`, go to GAP.
  - GAP: `dec_data_in_valid`=0 for exactly one cycle. Next state: DRAIN if `items_left`==0, else FETCH_CW if `flag_idx`==8, else FETCH_ITEM.
  - DRAIN: on the first cycle with `dec_busy`=0, pulse `done` and go to IDLE.
- `dec_data_in` and `dec_control_word_in` hold their values from FETCH_ITEM until the next item is loaded.
- Watchdog:
  - The counter clears on entry to ISSUE or DRAIN and on any cycle with `dec_busy`=0.
  - It counts cycles in ISSUE/DRAIN with `dec_busy`=1.
  - On reaching `WATCHDOG_CYCLES`: set `error`=1, pulse `done`, deassert `dec_data_in_valid`, go to IDLE.
- `abort` has priority over every transition. On the next edge: go to IDLE, all handshake outputs low, no `done`, `error` unchanged.
- `bytes_out` counts `dec_out_valid` in every state, including IDLE after a run.

## Timing
- Every output resets to 0 when `reset_n`=0, including `src_ready`, `bytes_out`, `error` and `done`. The state resets to IDLE. Reset is asynchronous and may hit mid-run; nothing is retained.
- Accepted `start` at edge N: `src_ready`=1 during cycle N+1.
- `start` with `item_count`==0: `done`=1 during cycle N+1 and no source transfer occurs.
- Best case, `src_valid` and `dec_busy`=0 held constant:
  - 3 cycles per item (FETCH_ITEM, ISSUE, GAP).
  - Plus 1 cycle per control word.
- Decompressor contract: it raises `dec_busy` no later than the cycle after acceptance. The one-cycle GAP covers that cycle, so one item is never accepted twice.
- `dec_data_in_valid` never rises in the cycle directly after an acceptance.
- `done` is high for exactly one cycle per run and never in the same cycle as `dec_data_in_valid`.

## Test plan
- `item_count`=3, control word 0x0020, items 0x0041, 0x0042, 0x1003; decompressor model busy 4 cycles per item → `dec_control_word_in` is 0, 0, 1 in that order; exactly 4 source transfers; one `done`; `error`=0.
- `item_count`=10, control words 0x00FF and 0x0000 → 12 source transfers; the second control word transfers right after the 8th item's GAP; items 9 and 10 carry flag 0.
- `start` with `item_count`=0 → `done` during cycle N+1; `src_ready` never 1; `busy` never 1.
- `WATCHDOG_CYCLES`=16, `dec_busy` stuck at 1 during ISSUE → `error`=1 and `done` pulse 16 cycles after ISSUE entry; `dec_data_in_valid`=0 afterwards.
- `abort` during ISSUE of the 2nd item → the next cycle shows `dec_data_in_valid`=0 and `busy`=0, with no `done`; a following `start` completes its run normally.
- 5 `dec_out_valid` pulses during a run, then `reset_n` pulsed low mid-stream → `bytes_out`=5 before the reset; immediately on reset assertion all outputs are 0, without waiting for a clock edge.

Source files
------------

// File: rtl/decompressor_sequencer.sv
// decompressor_sequencer: unpacks 8-flag control words and issues flagged 16-bit items to decompressor_top.
// Latency: 3 cycles per item plus 1 cycle per control word, measured with the source and decompressor never stalling.
// Backpressure: waits on src_valid in the fetch states and on dec_busy in issue/drain; a watchdog bounds the dec_busy wait.
module decompressor_sequencer #(
  parameter int COUNT_WIDTH      = 12,
  parameter int BYTE_COUNT_WIDTH = 16,
  parameter int WATCHDOG_CYCLES  = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [COUNT_WIDTH-1:0]      item_count,
  input  logic                        abort,
  input  logic [15:0]                 src_word,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic [15:0]                 dec_data_in,
  output logic                        dec_control_word_in,
  output logic                        dec_data_in_valid,
  input  logic                        dec_busy,
  input  logic                        dec_out_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [BYTE_COUNT_WIDTH-1:0] bytes_out
);

  localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_CW,
    S_FETCH_ITEM,
    S_ISSUE,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] items_left;
  logic [7:0]             flags;
  logic [3:0]             flag_idx;
  logic [WD_WIDTH-1:0]    wd_cnt;
  logic                   in_wait;
  logic                   wd_fire;
  logic                   run_start;
  logic                   done_nxt;
  logic                   err_set;
  logic                   cw_load;
  logic                   item_load;
  logic                   item_accept;

  // Only ISSUE and DRAIN wait on the decompressor, so only they are watched.
  assign in_wait = (state == S_ISSUE) || (state == S_DRAIN);
  assign wd_fire = in_wait && dec_busy && (wd_cnt == WD_LAST);

  // Next-state and handshake decode; abort overrides every transition and pulse.
  always_comb begin
    state_nxt         = state;
    src_ready         = 1'b0;
    dec_data_in_valid = 1'b0;
    busy              = (state != S_IDLE);
    run_start         = 1'b0;
    done_nxt          = 1'b0;
    err_set           = 1'b0;
    cw_load           = 1'b0;
    item_load         = 1'b0;
    item_accept       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (item_count == '0) begin
            done_nxt = 1'b1;
          end else begin
            run_start = 1'b1;
            state_nxt = S_FETCH_CW;
          end
        end
      end
      S_FETCH_CW: begin
        src_ready = 1'b1;
        if (src_valid) begin
          cw_load   = 1'b1;
          state_nxt = S_FETCH_ITEM;
        end
      end
      S_FETCH_ITEM: begin
        src_ready = 1'b1;
        if (src_valid) begin
          item_load = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dec_data_in_valid = 1'b1;
        if (!dec_busy) begin
          item_accept = 1'b1;
          state_nxt   = S_GAP;
        end else if (wd_fire) begin
          err_set   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        // One dead cycle gives the decompressor time to raise dec_busy.
        if (items_left == '0) begin
          state_nxt = S_DRAIN;
        end else if (flag_idx == 4'd8) begin
          state_nxt = S_FETCH_CW;
        end else begin
          state_nxt = S_FETCH_ITEM;
        end
      end
      S_DRAIN: begin
        if (!dec_busy) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (wd_fire) begin
          err_set   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt   = S_IDLE;
      run_start   = 1'b0;
      done_nxt    = 1'b0;
      err_set     = 1'b0;
      cw_load     = 1'b0;
      item_load   = 1'b0;
      item_accept = 1'b0;
    end
  end

  // State register and one-cycle done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Run bookkeeping: remaining items, current flag byte and position within the group.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      items_left <= '0;
      flags      <= '0;
      flag_idx   <= '0;
    end else begin
      if (run_start) begin
        items_left <= item_count;
      end else if (item_accept) begin
        items_left <= items_left - COUNT_WIDTH'(1);
      end
      if (cw_load) begin
        flags    <= src_word[7:0];
        flag_idx <= '0;
      end else if (item_accept) begin
        flag_idx <= flag_idx + 4'd1;
      end
    end
  end

  // Item register held steady until the next item is fetched; bit 7 flags the first item of a group.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_data_in         <= '0;
      dec_control_word_in <= 1'b0;
    end else if (item_load) begin
      dec_data_in         <= src_word;
      dec_control_word_in <= flags[3'd7 - flag_idx[2:0]];
    end
  end

  // Watchdog counts consecutive busy cycles while waiting; any idle cycle or state change clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (in_wait && dec_busy && (state_nxt == state)) begin
      wd_cnt <= wd_cnt + WD_WIDTH'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // Sticky hang flag, cleared only by a run that actually starts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (run_start) begin
      error <= 1'b0;
    end else if (err_set) begin
      error <= 1'b1;
    end
  end

  // Saturating output-byte counter, live in every state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bytes_out <= '0;
    end else if (run_start) begin
      bytes_out <= '0;
    end else if (dec_out_valid && (bytes_out != '1)) begin
      bytes_out <= bytes_out + BYTE_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decompressor_sequencer.sv
// tb_decompressor_sequencer: randomized source/decompressor environment with a stream-level reference model.
// Latency: directed runs pin start, best-case and watchdog timing to literal cycle counts.
// Backpressure: source valid and decompressor busy are randomized; every wait is bounded.
module tb_decompressor_sequencer;

  localparam int CW = 12;
  localparam int BW = 16;
  localparam int WD = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] item_count = '0;
  logic          abort = 1'b0;
  logic [15:0]   src_word = '0;
  logic          src_valid = 1'b0;
  logic          dec_busy = 1'b0;
  logic          dec_out_valid = 1'b0;
  logic          src_ready;
  logic [15:0]   dec_data_in;
  logic          dec_control_word_in;
  logic          dec_data_in_valid;
  logic          busy;
  logic          done;
  logic          error;
  logic [BW-1:0] bytes_out;

  decompressor_sequencer #(
    .COUNT_WIDTH(CW),
    .BYTE_COUNT_WIDTH(BW),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .item_count(item_count),
    .abort(abort),
    .src_word(src_word),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .dec_data_in(dec_data_in),
    .dec_control_word_in(dec_control_word_in),
    .dec_data_in_valid(dec_data_in_valid),
    .dec_busy(dec_busy),
    .dec_out_valid(dec_out_valid),
    .busy(busy),
    .done(done),
    .error(error),
    .bytes_out(bytes_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Stream under test and the items it must produce, as {flag, data}.
  logic [15:0] stream[$];
  logic [16:0] exp_q[$];
  int run_x0 = 0;
  int run_a0 = 0;
  int run_id = 0;
  int busy_mode = 0;   // 0 random 1..4 busy, 1 fixed 4, 2 never busy, 3 stuck busy
  int valid_pct = 100;
  int out_limit = -1;  // byte pulses allowed per run, negative = unlimited
  logic exp_error = 1'b0;
  bit chk_en = 1'b0;

  // Environment-owned state.
  int xfer_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int out_emitted = 0;
  int seen_run = 0;
  int dleft = 0;
  int cyc = 0;
  int xfer_edge[$];
  int acc_edge[$];
  logic [BW-1:0] exp_bytes = '0;
  bit last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source and decompressor models: sample at the edge, drive new inputs 1ns later.
  always @(posedge clock) begin : env
    bit xfer;
    bit acc;
    int sidx;
    xfer = src_valid && src_ready;
    acc  = dec_data_in_valid && !dec_busy;
    cyc++;
    if (xfer) begin
      xfer_cnt++;
      xfer_edge.push_back(cyc);
    end
    if (acc) begin
      acc_cnt++;
      acc_edge.push_back(cyc);
    end
    if (done) done_cnt++;
    last_acc = acc;
    if (!reset_n) exp_bytes = '0;
    else if (start && item_count != 0 && !abort) exp_bytes = '0;
    else if (dec_out_valid && exp_bytes != '1) exp_bytes = exp_bytes + 1'b1;
    if (seen_run != run_id) begin
      seen_run = run_id;
      out_emitted = 0;
    end
    if (dec_out_valid) out_emitted++;
    if (acc) dleft = (busy_mode == 1) ? 4 : int'($urandom_range(4, 1));
    else if (dleft > 0) dleft--;
    #1;
    sidx = xfer_cnt - run_x0;
    src_valid = (sidx < stream.size()) && (int'($urandom_range(99, 0)) < valid_pct);
    src_word = src_valid ? stream[sidx] : 16'($urandom);
    dec_busy = (busy_mode == 3) || (busy_mode != 2 && dleft > 0);
    dec_out_valid = dec_busy && (out_limit < 0 || out_emitted < out_limit) && ($urandom_range(1, 0) == 1);
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin : compare
    int k;
    if (chk_en) begin
      chk("bytes_out", bytes_out, exp_bytes);
      chk("error", error, exp_error);
      if (dec_data_in_valid) begin
        k = acc_cnt - run_a0;
        chk("item_expected", k < exp_q.size(), 1);
        if (k < exp_q.size()) begin
          chk("item_data", dec_data_in, exp_q[k][15:0]);
          chk("item_flag", dec_control_word_in, exp_q[k][16]);
        end
      end
      if (done) chk("done_excl_valid", dec_data_in_valid, 0);
      if (last_acc) chk("no_valid_after_accept", dec_data_in_valid, 0);
    end
  end

  // Derive expected items from the stream: every 9th word is a control word, bit 7 flags the first item.
  task automatic load_model(input int n);
    logic [15:0] cwd;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      cwd = stream[(i / 8) * 9];
      exp_q.push_back({cwd[7 - (i % 8)], stream[(i / 8) * 9 + 1 + (i % 8)]});
    end
    run_x0 = xfer_cnt;
    run_a0 = acc_cnt;
    run_id++;
  endtask

  task automatic build_random(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 0) stream.push_back(16'($urandom));
      stream.push_back(16'($urandom));
    end
    load_model(n);
  endtask

  // Start pulse sampled at edge N; returns during cycle N+1.
  task automatic pulse_start(input int n);
    @(negedge clock);
    #1;
    item_count = CW'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (n != 0) exp_error = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_run(input int n, output int lat);
    int d0;
    d0 = done_cnt;
    pulse_start(n);
    chk("src_ready_at_n1", src_ready, 1);
    chk("busy_at_n1", busy, 1);
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clock);
      lat++;
    end
    chk("run_done_seen", done, 1);
    chk("run_xfers", xfer_cnt - run_x0, n + (n + 7) / 8);
    chk("run_accepts", acc_cnt - run_a0, n);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin : global_timeout
    #900000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    int w;
    int d0;
    int nlist[6];

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_valid", dec_data_in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_bytes", bytes_out, 0);
    chk("rst_data", dec_data_in, 0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;

    // Zero-length run: done in N+1, never ready or busy.
    d0 = done_cnt;
    pulse_start(0);
    chk("zero_done_n1", done, 1);
    chk("zero_src_ready", src_ready, 0);
    chk("zero_busy", busy, 0);
    repeat (4) begin
      @(negedge clock);
      chk("zero_quiet_ready", src_ready, 0);
      chk("zero_quiet_busy", busy, 0);
      chk("zero_quiet_done", done, 0);
    end
    chk("zero_done_count", done_cnt - d0, 1);

    // Directed: 3 items under flag word 0x0020, decompressor busy 4 cycles each.
    busy_mode = 1;
    stream.delete();
    stream.push_back(16'h0020);
    stream.push_back(16'h0041);
    stream.push_back(16'h0042);
    stream.push_back(16'h1003);
    load_model(3);
    chk("model_t1_flag0", exp_q[0][16], 0);
    chk("model_t1_flag1", exp_q[1][16], 0);
    chk("model_t1_flag2", exp_q[2][16], 1);
    chk("model_t1_data2", exp_q[2][15:0], 16'h1003);
    do_run(3, lat);

    // Directed: 10 items spanning two control words.
    busy_mode = 0;
    stream.delete();
    stream.push_back(16'h00FF);
    for (int i = 0; i < 8; i++) stream.push_back(16'($urandom));
    stream.push_back(16'h0000);
    stream.push_back(16'($urandom));
    stream.push_back(16'($urandom));
    load_model(10);
    chk("model_t2_flag0", exp_q[0][16], 1);
    chk("model_t2_flag8", exp_q[8][16], 0);
    chk("model_t2_flag9", exp_q[9][16], 0);
    do_run(10, lat);
    chk("t2_cw2_after_gap", xfer_edge[run_x0 + 9] - acc_edge[run_a0 + 7], 2);

    // Best case: no stalls anywhere, 3 per item + 1 per control word + drain.
    busy_mode = 2;
    build_random(10);
    do_run(10, lat);
    chk("best_case_done_cycle", lat, 34);

    // Randomized runs including exact group boundaries.
    busy_mode = 0;
    nlist[0] = 8;
    nlist[1] = 16;
    nlist[2] = 1;
    for (int r = 3; r < 6; r++) nlist[r] = int'($urandom_range(40, 2));
    for (int r = 0; r < 6; r++) begin
      valid_pct = int'($urandom_range(100, 40));
      build_random(nlist[r]);
      do_run(nlist[r], lat);
    end
    valid_pct = 100;

    // Watchdog: decompressor stuck busy during the first ISSUE.
    busy_mode = 3;
    build_random(2);
    d0 = done_cnt;
    pulse_start(2);
    w = 0;
    while (!dec_data_in_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("wd_issue_reached", dec_data_in_valid, 1);
    for (int k = 1; k < WD; k++) begin
      @(negedge clock);
      chk("wd_no_early_done", done, 0);
      chk("wd_valid_held", dec_data_in_valid, 1);
    end
    #1 exp_error = 1'b1;
    @(negedge clock);
    chk("wd_done", done, 1);
    chk("wd_error", error, 1);
    chk("wd_valid_low", dec_data_in_valid, 0);
    chk("wd_busy_low", busy, 0);
    busy_mode = 0;
    @(negedge clock);
    chk("wd_done_single", done, 0);
    chk("wd_done_count", done_cnt - d0, 1);
    chk("wd_valid_stays_low", dec_data_in_valid, 0);

    // Abort during ISSUE of the second item, then a clean run.
    busy_mode = 1;
    build_random(4);
    d0 = done_cnt;
    pulse_start(4);
    w = 0;
    while (!(dec_data_in_valid && (acc_cnt - run_a0) == 1) && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("abort_reached_issue2", dec_data_in_valid && (acc_cnt - run_a0) == 1, 1);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("abort_valid_low", dec_data_in_valid, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_src_ready_low", src_ready, 0);
    chk("abort_no_done", done, 0);
    repeat (6) begin
      @(negedge clock);
      chk("abort_quiet_done", done, 0);
    end
    chk("abort_done_count", done_cnt - d0, 0);
    build_random(5);
    do_run(5, lat);

    // Five output bytes, then asynchronous reset mid-run.
    out_limit = 5;
    build_random(16);
    pulse_start(16);
    w = 0;
    while (out_emitted < 5 && w < 500) begin
      @(negedge clock);
      w++;
    end
    chk("rst_mid_bytes", bytes_out, 5);
    chk("model_rst_bytes", exp_bytes, 5);
    chk("rst_mid_busy", busy, 1);
    #1 chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_src_ready", src_ready, 0);
    chk("arst_valid", dec_data_in_valid, 0);
    chk("arst_flag", dec_control_word_in, 0);
    chk("arst_data", dec_data_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_bytes", bytes_out, 0);
    stream.delete();
    exp_q.delete();
    exp_error = 1'b0;
    out_limit = -1;
    @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    valid_pct = 70;
    build_random(9);
    do_run(9, lat);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
